// File: rtl/register_file_mp_pkg.sv
// Shared types and constants for the multi-port register file.
// Imported by the interface, the read-port slice and the top level.
`timescale 1ns/1ps
package regfile_pkg;

  typedef enum logic [0:0] {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_e;

  localparam int MAX_NUM_RD = 4;

  // When both write ports hit the same address, the load-return port (B) is stored.
  localparam bit PORT_B_WINS = 1'b1;

endpackage

// File: rtl/register_file_mp_if.sv
// Bus bundle for register_file_mp: write ports, packed read ports, clear control,
// status flags and FSM debug visibility.
`timescale 1ns/1ps
interface register_file_mp_if
  import regfile_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);

  // Handshake: clear is a level request sampled only while idle; busy is high for
  // the whole sweep, and any write presented while busy is high is dropped, so the
  // writer must hold off until busy falls. There is no per-write acknowledge.
  logic                       clear;
  logic                       busy;
  logic                       wr_en_a;
  logic [ADDR_W-1:0]          wr_addr_a;
  logic [DATA_W-1:0]          wr_data_a;
  logic                       wr_en_b;
  logic [ADDR_W-1:0]          wr_addr_b;
  logic [DATA_W-1:0]          wr_data_b;
  logic [NUM_RD*ADDR_W-1:0]   rd_addr;
  logic [NUM_RD*DATA_W-1:0]   rd_data;
  logic                       wr_conflict;
  rf_state_e                  dbg_state;
  logic [ADDR_W-1:0]          dbg_cnt;

  modport slave (
    input  clear, wr_en_a, wr_addr_a, wr_data_a,
    input  wr_en_b, wr_addr_b, wr_data_b, rd_addr,
    output busy, rd_data, wr_conflict, dbg_state, dbg_cnt
  );

  modport master (
    output clear, wr_en_a, wr_addr_a, wr_data_a,
    output wr_en_b, wr_addr_b, wr_data_b, rd_addr,
    input  busy, rd_data, wr_conflict, dbg_state, dbg_cnt
  );

endinterface

// File: rtl/register_file_mp_read_port.sv
// One combinational read lane: busy masking, hardwired-zero entry and
// same-cycle write bypass on top of the raw array entry.
`timescale 1ns/1ps
module regfile_read_port #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              i_busy,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_entry,
  input  logic              i_we_a,
  input  logic [ADDR_W-1:0] i_wa_a,
  input  logic [DATA_W-1:0] i_wd_a,
  input  logic              i_we_b,
  input  logic [ADDR_W-1:0] i_wa_b,
  input  logic [DATA_W-1:0] i_wd_b,
  output logic [DATA_W-1:0] o_data
);

  logic w_zero_hit;
  logic w_hit_a;
  logic w_hit_b;

  // Write enables arriving here are already qualified as effective writes.
  assign w_zero_hit = (ZERO_REG != 0) && (i_addr == '0);
  assign w_hit_a    = (BYPASS != 0) && i_we_a && (i_wa_a == i_addr);
  assign w_hit_b    = (BYPASS != 0) && i_we_b && (i_wa_b == i_addr);

  always_comb begin
    o_data = i_entry;
    if (i_busy) begin
      o_data = '0;
    end else if (w_zero_hit) begin
      o_data = '0;
    end else if (w_hit_b) begin
      o_data = i_wd_b;
    end else if (w_hit_a) begin
      o_data = i_wd_a;
    end
  end

endmodule

// File: rtl/register_file_mp.sv
// Multi-port register file: two prioritised write ports, NUM_RD combinational
// read ports, and a one-entry-per-cycle bulk-clear sweep.
`timescale 1ns/1ps
module register_file_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic clk,
  input  logic rst,
  register_file_mp_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]        r_mem [DEPTH];
  rf_state_e                r_state;
  rf_state_e                w_state_next;
  logic [ADDR_W-1:0]        r_cnt;
  logic                     r_conflict;
  logic                     w_busy;
  logic                     w_eff_a;
  logic                     w_eff_b;
  logic                     w_same;
  logic [NUM_RD*DATA_W-1:0] w_rd_data;

  assign w_busy  = (r_state == RF_CLEAR);
  assign w_eff_a = bus.wr_en_a && !w_busy && !((ZERO_REG != 0) && (bus.wr_addr_a == '0));
  assign w_eff_b = bus.wr_en_b && !w_busy && !((ZERO_REG != 0) && (bus.wr_addr_b == '0));
  assign w_same  = w_eff_a && w_eff_b && (bus.wr_addr_a == bus.wr_addr_b);

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      RF_IDLE:  if (bus.clear) w_state_next = RF_CLEAR;
      RF_CLEAR: if (r_cnt == {ADDR_W{1'b1}}) w_state_next = RF_IDLE;
      default:  w_state_next = RF_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= RF_IDLE;
      r_cnt      <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_conflict <= w_same;
      if (r_state == RF_CLEAR) begin
        r_cnt <= r_cnt + 1'b1;
      end else if (bus.clear) begin
        r_cnt <= '0;
      end
    end
  end

  // Effective writes never coincide with the sweep, since busy gates both ports.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (r_state == RF_CLEAR) begin
      r_mem[r_cnt] <= '0;
    end else begin
      if (w_eff_a && !(w_same && PORT_B_WINS)) begin
        r_mem[bus.wr_addr_a] <= bus.wr_data_a;
      end
      if (w_eff_b && !(w_same && !PORT_B_WINS)) begin
        r_mem[bus.wr_addr_b] <= bus.wr_data_b;
      end
    end
  end

  for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
    logic [ADDR_W-1:0] w_addr;
    assign w_addr = bus.rd_addr[i*ADDR_W +: ADDR_W];

    regfile_read_port #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG),
      .BYPASS   (BYPASS)
    ) u_rd (
      .i_busy  (w_busy),
      .i_addr  (w_addr),
      .i_entry (r_mem[w_addr]),
      .i_we_a  (w_eff_a),
      .i_wa_a  (bus.wr_addr_a),
      .i_wd_a  (bus.wr_data_a),
      .i_we_b  (w_eff_b),
      .i_wa_b  (bus.wr_addr_b),
      .i_wd_b  (bus.wr_data_b),
      .o_data  (w_rd_data[i*DATA_W +: DATA_W])
    );
  end

  assign bus.rd_data     = w_rd_data;
  assign bus.busy        = w_busy;
  assign bus.wr_conflict = r_conflict;
  assign bus.dbg_state   = r_state;
  assign bus.dbg_cnt     = r_cnt;

endmodule

// File: tb/tb_register_file_mp.sv
// Bench for register_file_mp: a bypassing 2-read instance and a non-bypassing
// 4-read instance, checked through an expected-value queue.
`timescale 1ns/1ps
module tb_register_file_mp;
  import regfile_pkg::*;

  localparam int DW    = 32;
  localparam int AW    = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2)) bus ();
  register_file_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4)) bus4 ();

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  register_file_mp #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(4), .ZERO_REG(1), .BYPASS(0)) u_dut4 (
    .clk (clk),
    .rst (rst),
    .bus (bus4)
  );

  int          n_cmp = 0;
  int          n_err = 0;
  logic [DW-1:0] exp_q[$];
  logic [DW-1:0] exp_v;
  logic [DW-1:0] obs;
  logic [DW-1:0] model [DEPTH];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.clear = 1'b0;  bus.wr_en_a = 1'b0; bus.wr_addr_a = '0; bus.wr_data_a = '0;
    bus.wr_en_b = 1'b0; bus.wr_addr_b = '0; bus.wr_data_b = '0; bus.rd_addr = '0;
    bus4.clear = 1'b0; bus4.wr_en_a = 1'b0; bus4.wr_addr_a = '0; bus4.wr_data_a = '0;
    bus4.wr_en_b = 1'b0; bus4.wr_addr_b = '0; bus4.wr_data_b = '0; bus4.rd_addr = '0;
  endtask

  function automatic logic [DW-1:0] lane(input int p);
    return bus.rd_data[p*DW +: DW];
  endfunction

  function automatic logic [DW-1:0] lane4(input int p);
    return bus4.rd_data[p*DW +: DW];
  endfunction

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    exp_q.push_back('0);
    obs = DW'(bus.busy);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_busy: got %h want %h", obs, exp_v); end
    exp_q.push_back('0);
    obs = DW'(bus.wr_conflict);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (obs !== exp_v) begin n_err++; $display("FAIL reset_conflict: got %h want %h", obs, exp_v); end
    for (int k = 0; k < 4; k++) begin
      bus.rd_addr = {AW'($urandom_range(0, DEPTH-1)), AW'($urandom_range(0, DEPTH-1))};
      exp_q.push_back('0);
      exp_q.push_back('0);
      #1;
      for (int p = 0; p < 2; p++) begin
        exp_v = exp_q.pop_front(); n_cmp++;
        if (lane(p) !== exp_v) begin n_err++; $display("FAIL reset_rd lane%0d: got %h want %h", p, lane(p), exp_v); end
      end
    end
  endtask

  task automatic test_bypass();
    bus.wr_en_a = 1'b1; bus.wr_addr_a = 5'd3; bus.wr_data_a = 32'hDEADBEEF;
    bus.rd_addr = {5'd0, 5'd3};
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (lane(0) !== exp_v) begin n_err++; $display("FAIL bypass_same_cycle: got %h want %h", lane(0), exp_v); end
    tick();
    bus.wr_en_a = 1'b0;
    exp_q.push_back(32'hDEADBEEF);
    #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (lane(0) !== exp_v) begin n_err++; $display("FAIL bypass_after_edge: got %h want %h", lane(0), exp_v); end
  endtask

  task automatic test_conflict();
    bus.wr_en_a = 1'b1; bus.wr_addr_a = 5'd7; bus.wr_data_a = 32'h11;
    bus.wr_en_b = 1'b1; bus.wr_addr_b = 5'd7; bus.wr_data_b = 32'h22;
    bus.rd_addr = {5'd7, 5'd7};
    exp_q.push_back(32'h22);
    #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (lane(1) !== exp_v) begin n_err++; $display("FAIL conflict_same_cycle: got %h want %h", lane(1), exp_v); end
    tick();
    bus.wr_en_a = 1'b0; bus.wr_en_b = 1'b0;
    exp_q.push_back(32'h22);
    exp_q.push_back(32'h1);
    #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (lane(0) !== exp_v) begin n_err++; $display("FAIL conflict_stored: got %h want %h", lane(0), exp_v); end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (DW'(bus.wr_conflict) !== exp_v) begin n_err++; $display("FAIL conflict_flag_set: got %h want %h", bus.wr_conflict, exp_v); end
    tick();
    exp_q.push_back('0);
    exp_v = exp_q.pop_front(); n_cmp++;
    if (DW'(bus.wr_conflict) !== exp_v) begin n_err++; $display("FAIL conflict_flag_clear: got %h want %h", bus.wr_conflict, exp_v); end
    // distinct addresses: both commit and no conflict
    bus.wr_en_a = 1'b1; bus.wr_addr_a = 5'd8; bus.wr_data_a = 32'h88;
    bus.wr_en_b = 1'b1; bus.wr_addr_b = 5'd9; bus.wr_data_b = 32'h99;
    tick();
    bus.wr_en_a = 1'b0; bus.wr_en_b = 1'b0;
    bus.rd_addr = {5'd9, 5'd8};
    exp_q.push_back(32'h88); exp_q.push_back(32'h99); exp_q.push_back('0);
    #1;
    for (int p = 0; p < 2; p++) begin
      exp_v = exp_q.pop_front(); n_cmp++;
      if (lane(p) !== exp_v) begin n_err++; $display("FAIL dual_write lane%0d: got %h want %h", p, lane(p), exp_v); end
    end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (DW'(bus.wr_conflict) !== exp_v) begin n_err++; $display("FAIL dual_write_conflict: got %h want %h", bus.wr_conflict, exp_v); end
  endtask

  task automatic test_zero_reg();
    bus.wr_en_a = 1'b1; bus.wr_addr_a = 5'd0; bus.wr_data_a = 32'hFFFFFFFF;
    bus.wr_en_b = 1'b1; bus.wr_addr_b = 5'd0; bus.wr_data_b = 32'h1234;
    bus.rd_addr = {5'd0, 5'd0};
    exp_q.push_back('0); exp_q.push_back('0);
    #1;
    for (int p = 0; p < 2; p++) begin
      exp_v = exp_q.pop_front(); n_cmp++;
      if (lane(p) !== exp_v) begin n_err++; $display("FAIL zero_same_cycle lane%0d: got %h want %h", p, lane(p), exp_v); end
    end
    tick();
    bus.wr_en_a = 1'b0; bus.wr_en_b = 1'b0;
    exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0);
    #1;
    for (int p = 0; p < 2; p++) begin
      exp_v = exp_q.pop_front(); n_cmp++;
      if (lane(p) !== exp_v) begin n_err++; $display("FAIL zero_after lane%0d: got %h want %h", p, lane(p), exp_v); end
    end
    exp_v = exp_q.pop_front(); n_cmp++;
    if (DW'(bus.wr_conflict) !== exp_v) begin n_err++; $display("FAIL zero_conflict: got %h want %h", bus.wr_conflict, exp_v); end
  endtask

  task automatic test_no_bypass();
    bus4.wr_en_b = 1'b1; bus4.wr_addr_b = 5'd5; bus4.wr_data_b = 32'hA5;
    bus4.rd_addr = {4{5'd5}};
    for (int p = 0; p < 4; p++) exp_q.push_back('0);
    #1;
    for (int p = 0; p < 4; p++) begin
      exp_v = exp_q.pop_front(); n_cmp++;
      if (lane4(p) !== exp_v) begin n_err++; $display("FAIL nobyp_same_cycle lane%0d: got %h want %h", p, lane4(p), exp_v); end
    end
    tick();
    bus4.wr_en_b = 1'b0;
    for (int p = 0; p < 4; p++) exp_q.push_back(32'hA5);
    #1;
    for (int p = 0; p < 4; p++) begin
      exp_v = exp_q.pop_front(); n_cmp++;
      if (lane4(p) !== exp_v) begin n_err++; $display("FAIL nobyp_next_cycle lane%0d: got %h want %h", p, lane4(p), exp_v); end
    end
  endtask

  task automatic test_clear();
    int n;
    int a;
    for (int i = 1; i < DEPTH; i++) begin
      if (i % 2 == 1) begin
        bus.wr_en_b = 1'b1; bus.wr_addr_b = AW'(i); bus.wr_data_b = DW'(i);
      end else begin
        bus.wr_en_a = 1'b1; bus.wr_addr_a = AW'(i); bus.wr_data_a = DW'(i);
      end
      tick();
      bus.wr_en_a = 1'b0; bus.wr_en_b = 1'b0;
    end
    for (int k = 0; k < 4; k++) begin
      a = $urandom_range(1, DEPTH-1);
      bus.rd_addr = {5'd0, AW'(a)};
      exp_q.push_back(DW'(a));
      #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (lane(0) !== exp_v) begin n_err++; $display("FAIL fill addr%0d: got %h want %h", a, lane(0), exp_v); end
    end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    n = 0;
    while (bus.busy && n < 100) begin
      bus.clear = (n == 5);
      bus.wr_en_a = 1'b1; bus.wr_addr_a = AW'(n % 31 + 1); bus.wr_data_a = 32'hBAD00000 | DW'(n);
      if (n == 3) begin
        bus.rd_addr = {5'd0, 5'd20};
        exp_q.push_back('0);
        #1;
        exp_v = exp_q.pop_front(); n_cmp++;
        if (lane(0) !== exp_v) begin n_err++; $display("FAIL clear_busy_mask: got %h want %h", lane(0), exp_v); end
      end
      n++;
      tick();
    end
    bus.wr_en_a = 1'b0; bus.clear = 1'b0;
    exp_q.push_back(DW'(DEPTH));
    exp_v = exp_q.pop_front(); n_cmp++;
    if (DW'(n) !== exp_v) begin n_err++; $display("FAIL clear_busy_cycles: got %0d want %0d", n, exp_v); end
    for (int i = 0; i < DEPTH; i++) begin
      bus.rd_addr = {AW'(DEPTH-1-i), AW'(i)};
      exp_q.push_back('0); exp_q.push_back('0);
      #1;
      for (int p = 0; p < 2; p++) begin
        exp_v = exp_q.pop_front(); n_cmp++;
        if (lane(p) !== exp_v) begin n_err++; $display("FAIL clear_zeroed entry%0d lane%0d: got %h want %h", i, p, lane(p), exp_v); end
      end
    end
  endtask

  task automatic test_rst_during_clear();
    int n;
    bus.wr_en_a = 1'b1; bus.wr_addr_a = 5'd30; bus.wr_data_a = 32'h3030;
    tick();
    bus.wr_en_a = 1'b0;
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.rd_addr = {5'd29, 5'd30};
    exp_q.push_back('0); exp_q.push_back('0); exp_q.push_back('0);
    #1;
    exp_v = exp_q.pop_front(); n_cmp++;
    if (DW'(bus.busy) !== exp_v) begin n_err++; $display("FAIL abort_busy: got %h want %h", bus.busy, exp_v); end
    for (int p = 0; p < 2; p++) begin
      exp_v = exp_q.pop_front(); n_cmp++;
      if (lane(p) !== exp_v) begin n_err++; $display("FAIL abort_zeroed lane%0d: got %h want %h", p, lane(p), exp_v); end
    end
    bus.clear = 1'b1;
    tick();
    bus.clear = 1'b0;
    n_cmp++;
    if (bus.dbg_state !== RF_CLEAR) begin n_err++; $display("FAIL restart_state: got %0d want %0d", bus.dbg_state, RF_CLEAR); end
    n = 0;
    while (bus.busy && n < 100) begin
      if (n <= 1) begin
        exp_q.push_back(DW'(n));
        exp_v = exp_q.pop_front(); n_cmp++;
        if (DW'(bus.dbg_cnt) !== exp_v) begin n_err++; $display("FAIL restart_cnt step%0d: got %0d want %0d", n, bus.dbg_cnt, exp_v); end
      end
      n++;
      tick();
    end
    exp_q.push_back(DW'(DEPTH));
    exp_v = exp_q.pop_front(); n_cmp++;
    if (DW'(n) !== exp_v) begin n_err++; $display("FAIL restart_busy_cycles: got %0d want %0d", n, exp_v); end
  endtask

  function automatic logic [DW-1:0] model_rd(input logic [AW-1:0] ad,
      input logic ea, input logic [AW-1:0] aa, input logic [DW-1:0] da,
      input logic eb, input logic [AW-1:0] ab, input logic [DW-1:0] db);
    if (ad == '0) return '0;
    if (eb && ab == ad) return db;
    if (ea && aa == ad) return da;
    return model[ad];
  endfunction

  task automatic test_back_to_back();
    logic ea, eb;
    logic [AW-1:0] aa, ab, r;
    logic [DW-1:0] da, db;
    do_reset();
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
    for (int it = 0; it < 24; it++) begin
      ea = 1'($urandom_range(0, 1)); eb = 1'($urandom_range(0, 1));
      aa = AW'($urandom_range(0, 7)); ab = AW'($urandom_range(0, 7)); r = AW'($urandom_range(0, 7));
      da = $urandom; db = $urandom;
      bus.wr_en_a = ea; bus.wr_addr_a = aa; bus.wr_data_a = da;
      bus.wr_en_b = eb; bus.wr_addr_b = ab; bus.wr_data_b = db;
      bus.rd_addr = {r, aa};
      exp_q.push_back(model_rd(aa, ea, aa, da, eb, ab, db));
      exp_q.push_back(model_rd(r, ea, aa, da, eb, ab, db));
      #1;
      for (int p = 0; p < 2; p++) begin
        exp_v = exp_q.pop_front(); n_cmp++;
        if (lane(p) !== exp_v) begin n_err++; $display("FAIL b2b it%0d lane%0d: got %h want %h", it, p, lane(p), exp_v); end
      end
      exp_q.push_back(DW'(ea && eb && aa == ab && aa != '0));
      if (ea && aa != '0) model[aa] = da;
      if (eb && ab != '0) model[ab] = db;
      tick();
      exp_v = exp_q.pop_front(); n_cmp++;
      if (DW'(bus.wr_conflict) !== exp_v) begin n_err++; $display("FAIL b2b_conflict it%0d: got %h want %h", it, bus.wr_conflict, exp_v); end
    end
    bus.wr_en_a = 1'b0; bus.wr_en_b = 1'b0;
    for (int i = 1; i < 8; i++) begin
      bus.rd_addr = {5'd0, AW'(i)};
      exp_q.push_back(model[i]);
      #1;
      exp_v = exp_q.pop_front(); n_cmp++;
      if (lane(0) !== exp_v) begin n_err++; $display("FAIL b2b_final entry%0d: got %h want %h", i, lane(0), exp_v); end
    end
  endtask

  initial begin
    rst = 1'b1;
    idle_inputs();
    test_reset();
    test_bypass();
    test_conflict();
    test_zero_reg();
    test_no_bypass();
    test_clear();
    test_rst_during_clear();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
